modexp_stream: RTL and testbench



---
 rtl/modexp_stream.sv | 144 ++++++++++++++
 tb/tb_modexp_stream.sv | 138 +++++++++++++
 2 files changed

// File: rtl/modexp_stream.sv
// modexp_stream: streaming base^exponent mod modulus using one shared bit-serial Blakley multiplier.
module modexp_stream #(
  parameter int WIDTH     = 4096,
  parameter int EXP_WIDTH = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 err
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(EXP_WIDTH + 1);
  typedef enum logic [2:0] {IDLE, REDUCE, SCAN, SQR, MUL, DONE} state_t;
  state_t               r_state;
  logic [WIDTH-1:0]     r_p, r_a, r_b, r_r, r_n, r_res;
  logic [EXP_WIDTH-1:0] r_e;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_i;
  logic                 r_in_ready, r_out_valid, r_err;
  logic [WIDTH-1:0]     w_add, w_s2, w_one;
  logic [WIDTH+1:0]     w_s0, w_s1, w_nx;
  logic                 w_last;
  // REDUCE feeds a constant 1 so the same shift-add-subtract step reduces the base
  assign w_add  = (r_state == REDUCE) ? WIDTH'(1) : (r_state == SQR) ? r_r : r_b;
  assign w_nx   = {2'b00, r_n};
  assign w_s0   = {1'b0, r_p, 1'b0} + (r_a[WIDTH-1] ? {2'b00, w_add} : '0);
  assign w_s1   = (w_s0 >= w_nx) ? w_s0 - w_nx : w_s0;
  assign w_s2   = WIDTH'((w_s1 >= w_nx) ? w_s1 - w_nx : w_s1);
  assign w_one  = WIDTH'(r_n != WIDTH'(1));
  assign w_last = (r_cnt == '0);
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_res;
  assign err       = r_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_p         <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_r         <= '0;
      r_n         <= '0;
      r_res       <= '0;
      r_e         <= '0;
      r_cnt       <= '0;
      r_i         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_n        <= modulus;
          r_e        <= exponent;
          r_in_ready <= 1'b0;
          if (modulus == '0) begin
            r_state     <= DONE;
            r_res       <= '0;
            r_err       <= 1'b1;
            r_out_valid <= 1'b1;
          end else begin
            // the first reduction step (top base bit) is folded into the accept edge
            r_state <= REDUCE;
            r_p     <= WIDTH'(base[WIDTH-1] && modulus != WIDTH'(1));
            r_a     <= base << 1;
            r_cnt   <= CW'(WIDTH - 2);
          end
        end
        REDUCE: begin
          r_p   <= w_s2;
          r_a   <= r_a << 1;
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_b     <= w_s2;
            r_p     <= '0;
            r_i     <= IW'(EXP_WIDTH - 1);
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (r_e[EXP_WIDTH-1]) begin
            r_r <= r_b;
            if (r_i == '0) begin
              r_state     <= DONE;
              r_res       <= r_b;
              r_err       <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_e     <= r_e << 1;
              r_i     <= r_i - IW'(1);
              r_a     <= r_b;
              r_p     <= '0;
              r_cnt   <= CW'(WIDTH - 1);
              r_state <= SQR;
            end
          end else if (r_i == '0) begin
            r_state     <= DONE;
            r_res       <= w_one;
            r_err       <= 1'b0;
            r_out_valid <= 1'b1;
          end else begin
            r_e <= r_e << 1;
            r_i <= r_i - IW'(1);
          end
        end
        SQR, MUL: begin
          r_p   <= w_s2;
          r_a   <= r_a << 1;
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_r   <= w_s2;
            r_p   <= '0;
            r_a   <= w_s2;
            r_cnt <= CW'(WIDTH - 1);
            if (r_state == SQR && r_e[EXP_WIDTH-1]) r_state <= MUL;
            else if (r_i == '0) begin
              r_state     <= DONE;
              r_res       <= w_s2;
              r_err       <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_e     <= r_e << 1;
              r_i     <= r_i - IW'(1);
              r_state <= SQR;
            end
          end
        end
        DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_modexp_stream.sv
// tb_modexp_stream: directed and random checks of modexp_stream against an arithmetic reference model.
module tb_modexp_stream;
  localparam int W  = 16;
  localparam int EW = 16;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  base = '0;
  logic [EW-1:0] exponent = '0;
  logic [W-1:0]  modulus = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;
  logic          err;
  int checks = 0;
  int errors = 0;

  modexp_stream #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .base(base), .exponent(exponent), .modulus(modulus),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mexp(input logic [W-1:0] b, input logic [EW-1:0] e, input logic [W-1:0] n);
    longint unsigned r, bb, nn;
    if (n == 0) return '0;
    nn = longint'(n);
    r  = 1 % nn;
    bb = longint'(b) % nn;
    for (int i = 0; i < EW; i++) begin
      if (e[i]) r = (r * bb) % nn;
      bb = (bb * bb) % nn;
    end
    return W'(r);
  endfunction

  function automatic int lat_of(input logic [EW-1:0] e, input logic [W-1:0] n);
    int k;
    if (n == 0) return 1;
    if (e == 0) return W + EW;
    k = 0;
    for (int i = 0; i < EW; i++) if (e[i]) k = i;
    return W + (EW - 1 - k + 1) + W * (k + $countones(e) - 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run(input logic [W-1:0] b, input logic [EW-1:0] e, input logic [W-1:0] n, input int hold);
    logic [W-1:0] er;
    int el, lat;
    er = mexp(b, e, n);
    el = lat_of(e, n);
    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready), 64'(1));
    base = b; exponent = e; modulus = n; in_valid = 1'b1;
    @(negedge clk);
    // in_valid stays high with other operands while busy; the engine must ignore it
    base = ~b; exponent = ~e; modulus = n + 16'd1;
    lat = 1;
    while (!out_valid && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", 64'(lat), 64'(el));
    chk("result", 64'(result), 64'(er));
    chk("err", 64'(err), 64'(n == 0));
    chk("in_ready_done", 64'(in_ready), 64'(0));
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_result", 64'(result), 64'(er));
      chk("hold_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid", 64'(out_valid), 64'(0));
    chk("release_ready", 64'(in_ready), 64'(1));
    chk("retained_result", 64'(result), 64'(er));
  endtask

  initial begin
    logic [W-1:0]  rb, rn;
    logic [EW-1:0] re;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    run(16'd8, 16'd13, 16'd77, 0);
    chk("example_8_13_77", 64'(result), 64'(50));
    run(16'd50, 16'd37, 16'd77, 0);
    chk("chain_50_37_77", 64'(result), 64'(8));
    run(16'd85, 16'd13, 16'd77, 0);
    run(16'd8, 16'd0, 16'd77, 0);
    run(16'd8, 16'd0, 16'd1, 0);
    run(16'd0, 16'd5, 16'd77, 0);
    run(16'd123, 16'd45, 16'd1, 0);
    run(16'd5, 16'd9, 16'd0, 0);
    run(16'd8, 16'd13, 16'd77, 0);
    run(16'hFFFF, 16'hFFFF, 16'hFFFF, 0);
    run(16'd12345, 16'd1, 16'd1000, 0);
    run(16'd3, 16'h8000, 16'd65521, 0);
    run(16'd8, 16'd13, 16'd77, 20);
    // abort in the middle of the first squaring
    @(negedge clk);
    base = 16'd8; exponent = 16'd13; modulus = 16'd77; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_in_ready", 64'(in_ready), 64'(1));
    chk("abort_result", 64'(result), 64'(0));
    run(16'd8, 16'd13, 16'd77, 0);
    for (int t = 0; t < 20; t++) begin
      rb = W'($urandom);
      re = EW'($urandom) >> $urandom_range(0, 15);
      rn = (t % 4 == 0) ? W'($urandom_range(1, 40)) : W'($urandom);
      run(rb, re, rn, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
